// File: rtl/usr_seq_ctrl_pkg.sv
// Shared definitions for the universal-shift-register sequencer: FSM states,
// arbiter grant encoding, shift-register mode codes and frame width.
package usr_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TX_SHIFT = 2'd1,
        ST_RX_SHIFT = 2'd2,
        ST_RX_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        GRANT_TX = 1'b0,
        GRANT_RX = 1'b1
    } grant_e;

    localparam int FRAME_W = 4;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    localparam logic [1:0] LAST_BIT = 2'(FRAME_W - 1);

endpackage

// File: rtl/usr_seq_ctrl.sv
// Sequencer driving an external 4-bit universal shift register as either a
// TX serializer or an RX deserializer, with round-robin arbitration in IDLE.
module usr_seq_ctrl
    import usr_seq_ctrl_pkg::*;
#(
    parameter logic FILL = 1'b0
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_dir,
    output logic               ser_out,
    output logic               ser_out_valid,
    input  logic               rx_req,
    input  logic               rx_dir,
    output logic               rx_ack,
    input  logic               ser_in,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [FRAME_W-1:0] rx_data,
    output logic               busy,
    output logic [1:0]         usr_s,
    output logic [FRAME_W-1:0] usr_i,
    output logic               usr_msb_in,
    output logic               usr_lsb_in,
    input  logic [FRAME_W-1:0] usr_a
);

    state_e     state_q, state_d;
    logic [1:0] bit_cnt_q, bit_cnt_d;
    logic       dir_q, dir_d;
    grant_e     last_grant_q, last_grant_d;

    logic tx_win;
    logic rx_win;

    // On a tie the side that was not served last wins.
    assign tx_win = tx_valid && (!rx_req || (last_grant_q == GRANT_RX));
    assign rx_win = rx_req && (!tx_valid || (last_grant_q == GRANT_TX));

    assign rx_data = usr_a;
    assign busy    = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 2'd0;
            dir_q        <= 1'b0;
            last_grant_q <= GRANT_RX;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            dir_q        <= dir_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        dir_d         = dir_q;
        last_grant_d  = last_grant_q;
        tx_ready      = 1'b0;
        rx_ack        = 1'b0;
        ser_out       = 1'b0;
        ser_out_valid = 1'b0;
        rx_valid      = 1'b0;
        usr_s         = USR_HOLD;
        usr_i         = '0;
        usr_msb_in    = 1'b0;
        usr_lsb_in    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_win) begin
                    tx_ready     = 1'b1;
                    usr_s        = USR_LOAD;
                    usr_i        = tx_data;
                    state_d      = ST_TX_SHIFT;
                    bit_cnt_d    = 2'd0;
                    dir_d        = tx_dir;
                    last_grant_d = GRANT_TX;
                end else if (rx_win) begin
                    rx_ack       = 1'b1;
                    state_d      = ST_RX_SHIFT;
                    bit_cnt_d    = 2'd0;
                    dir_d        = rx_dir;
                    last_grant_d = GRANT_RX;
                end
            end

            ST_TX_SHIFT: begin
                ser_out_valid = 1'b1;
                ser_out       = dir_q ? usr_a[FRAME_W-1] : usr_a[0];
                if (dir_q) begin
                    usr_s      = USR_SHL;
                    usr_lsb_in = FILL;
                end else begin
                    usr_s      = USR_SHR;
                    usr_msb_in = FILL;
                end
                bit_cnt_d = bit_cnt_q + 2'd1;
                // A pending RX request blocks the gapless reload so it gets its turn.
                if (bit_cnt_q == LAST_BIT) begin
                    if (tx_valid && !rx_req) begin
                        tx_ready     = 1'b1;
                        usr_s        = USR_LOAD;
                        usr_i        = tx_data;
                        bit_cnt_d    = 2'd0;
                        dir_d        = tx_dir;
                        last_grant_d = GRANT_TX;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_RX_SHIFT: begin
                if (dir_q) begin
                    usr_s      = USR_SHL;
                    usr_lsb_in = ser_in;
                end else begin
                    usr_s      = USR_SHR;
                    usr_msb_in = ser_in;
                end
                bit_cnt_d = bit_cnt_q + 2'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_RX_DONE;
                end
            end

            ST_RX_DONE: begin
                rx_valid = 1'b1;
                if (rx_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset loads zero into the shift register on the same edge.
        if (!clear_n) begin
            tx_ready      = 1'b0;
            rx_ack        = 1'b0;
            ser_out       = 1'b0;
            ser_out_valid = 1'b0;
            rx_valid      = 1'b0;
            usr_s         = USR_LOAD;
            usr_i         = '0;
        end
    end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Directed self-checking bench for usr_seq_ctrl; includes a behavioural
// universal shift register so usr_a responds to the controller's commands.
module tb_usr_seq_ctrl;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] tx_data;
    logic       tx_dir;
    logic       ser_out;
    logic       ser_out_valid;
    logic       rx_req;
    logic       rx_dir;
    logic       rx_ack;
    logic       ser_in;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] rx_data;
    logic       busy;
    logic [1:0] usr_s;
    logic [3:0] usr_i;
    logic       usr_msb_in;
    logic       usr_lsb_in;
    logic [3:0] usr_a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usr_seq_ctrl #(.FILL(1'b0)) dut (
        .clk           (clk),
        .clear_n       (clear_n),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_dir        (tx_dir),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .rx_req        (rx_req),
        .rx_dir        (rx_dir),
        .rx_ack        (rx_ack),
        .ser_in        (ser_in),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .busy          (busy),
        .usr_s         (usr_s),
        .usr_i         (usr_i),
        .usr_msb_in    (usr_msb_in),
        .usr_lsb_in    (usr_lsb_in),
        .usr_a         (usr_a)
    );

    // Behavioural universal shift register (its own clear tied low).
    always @(posedge clk) begin
        case (usr_s)
            2'b01:   usr_a <= {usr_msb_in, usr_a[3:1]};
            2'b10:   usr_a <= {usr_a[2:0], usr_lsb_in};
            2'b11:   usr_a <= usr_i;
            default: usr_a <= usr_a;
        endcase
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        clear_n  = 1'b0;
        tx_valid = 1'b0;
        rx_req   = 1'b0;
        rx_ready = 1'b0;
        ser_in   = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_n  = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 4'hA;
        rx_req   = 1'b1;
        #1;
        checks++; if (usr_s !== 2'b11) begin errors++; $display("[TB] FAIL reset_usr_s got %b exp 11", usr_s); end
        checks++; if (usr_i !== 4'h0) begin errors++; $display("[TB] FAIL reset_usr_i got %h exp 0", usr_i); end
        checks++; if ({tx_ready, rx_ack, ser_out_valid, rx_valid} !== 4'b0000) begin errors++;
            $display("[TB] FAIL reset_outputs got %b exp 0000", {tx_ready, rx_ack, ser_out_valid, rx_valid}); end
        @(negedge clk);
        clear_n  = 1'b1;
        tx_valid = 1'b0;
        rx_req   = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy got %b exp 0", busy); end
        checks++; if (ser_out !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_ser_out got %b exp 0", ser_out); end
        checks++; if (usr_a !== 4'h0) begin errors++; $display("[TB] FAIL post_reset_usr_a got %h exp 0", usr_a); end
    endtask

    // seq[k] is the bit expected on ser_out k+1 cycles after the handshake.
    task automatic test_tx(input logic [3:0] word, input logic dir, input logic [3:0] seq);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = word;
        tx_dir   = dir;
        #1;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL tx_handshake_ready got %b exp 1", tx_ready); end
        checks++; if (usr_s !== 2'b11 || usr_i !== word) begin errors++;
            $display("[TB] FAIL tx_load got s=%b i=%h exp s=11 i=%h", usr_s, usr_i, word); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            #1;
            checks++; if (ser_out_valid !== 1'b1 || ser_out !== seq[k]) begin errors++;
                $display("[TB] FAIL tx_bit%0d got v=%b d=%b exp v=1 d=%b", k, ser_out_valid, ser_out, seq[k]); end
            checks++; if (usr_s !== (dir ? 2'b10 : 2'b01)) begin errors++;
                $display("[TB] FAIL tx_mode%0d got %b exp %b", k, usr_s, dir ? 2'b10 : 2'b01); end
        end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0 || ser_out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL tx_end got busy=%b v=%b exp 0 0", busy, ser_out_valid); end
        checks++; if (usr_a !== 4'h0) begin errors++; $display("[TB] FAIL tx_fill got %h exp 0", usr_a); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp8;
        exp8 = 8'b01101011;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 4'b1011;
        tx_dir   = 1'b0;
        #1;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_ready got %b exp 1", tx_ready); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) tx_data = 4'b0110;
            if (k == 4) tx_valid = 1'b0;
            #1;
            checks++; if (ser_out_valid !== 1'b1 || ser_out !== exp8[k]) begin errors++;
                $display("[TB] FAIL b2b_bit%0d got v=%b d=%b exp v=1 d=%b", k, ser_out_valid, ser_out, exp8[k]); end
            checks++; if (tx_ready !== (k == 3)) begin errors++;
                $display("[TB] FAIL b2b_ready%0d got %b exp %b", k, tx_ready, k == 3); end
        end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_rx(input logic dir, input logic [3:0] seq, input logic [3:0] exp_data);
        @(negedge clk);
        rx_req = 1'b1;
        rx_dir = dir;
        #1;
        checks++; if (rx_ack !== 1'b1 || usr_s !== 2'b00) begin errors++;
            $display("[TB] FAIL rx_ack got ack=%b s=%b exp 1 00", rx_ack, usr_s); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rx_req = 1'b0;
            ser_in = seq[k];
            #1;
            checks++; if (rx_valid !== 1'b0 || busy !== 1'b1) begin errors++;
                $display("[TB] FAIL rx_shift%0d got valid=%b busy=%b exp 0 1", k, rx_valid, busy); end
        end
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            ser_in = ~ser_in;
            #1;
            checks++; if (rx_valid !== 1'b1 || rx_data !== exp_data) begin errors++;
                $display("[TB] FAIL rx_hold%0d got v=%b d=%h exp v=1 d=%h", h, rx_valid, rx_data, exp_data); end
        end
        @(negedge clk);
        rx_ready = 1'b1;
        #1;
        checks++; if (rx_valid !== 1'b1 || rx_data !== exp_data) begin errors++;
            $display("[TB] FAIL rx_accept got v=%b d=%h exp v=1 d=%h", rx_valid, rx_data, exp_data); end
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
        checks++; if (rx_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("[TB] FAIL rx_idle got v=%b busy=%b exp 0 0", rx_valid, busy); end
    endtask

    task automatic test_arbitration();
        logic [3:0] seq;
        seq = 4'b1011;
        do_reset();
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 4'b1011;
        tx_dir   = 1'b0;
        rx_req   = 1'b1;
        rx_dir   = 1'b0;
        ser_in   = 1'b1;
        #1;
        checks++; if (tx_ready !== 1'b1 || rx_ack !== 1'b0) begin errors++;
            $display("[TB] FAIL arb_first got tx_ready=%b rx_ack=%b exp 1 0", tx_ready, rx_ack); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++; if (ser_out_valid !== 1'b1 || ser_out !== seq[k] || tx_ready !== 1'b0) begin errors++;
                $display("[TB] FAIL arb_tx_bit%0d got v=%b d=%b rdy=%b exp 1 %b 0", k, ser_out_valid, ser_out, tx_ready, seq[k]); end
        end
        @(negedge clk);
        #1;
        checks++; if (rx_ack !== 1'b1 || tx_ready !== 1'b0) begin errors++;
            $display("[TB] FAIL arb_second got rx_ack=%b tx_ready=%b exp 1 0", rx_ack, tx_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rx_req = 1'b0;
            #1;
            checks++; if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL arb_rx_ignore%0d got %b exp 0", k, tx_ready); end
        end
        @(negedge clk);
        rx_req   = 1'b1;
        rx_ready = 1'b1;
        #1;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 4'hF) begin errors++;
            $display("[TB] FAIL arb_rx_data got v=%b d=%h exp 1 f", rx_valid, rx_data); end
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
        checks++; if (tx_ready !== 1'b1 || rx_ack !== 1'b0) begin errors++;
            $display("[TB] FAIL arb_third got tx_ready=%b rx_ack=%b exp 1 0", tx_ready, rx_ack); end
        @(negedge clk);
        tx_valid = 1'b0;
        rx_req   = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL arb_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        @(negedge clk);
        rx_req = 1'b1;
        rx_dir = 1'b0;
        #1;
        checks++; if (rx_ack !== 1'b1) begin errors++; $display("[TB] FAIL abort_ack got %b exp 1", rx_ack); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rx_req = 1'b0;
            ser_in = 1'b1;
        end
        @(negedge clk);
        clear_n = 1'b0;
        #1;
        checks++; if (usr_s !== 2'b11 || rx_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL abort_during got s=%b v=%b exp 11 0", usr_s, rx_valid); end
        @(negedge clk);
        clear_n = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || usr_a !== 4'h0) begin errors++;
            $display("[TB] FAIL abort_after got busy=%b usr_a=%h exp 0 0", busy, usr_a); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_valid%0d got %b exp 0", k, rx_valid); end
        end
        test_tx(4'b0101, 1'b1, 4'b1010);
    endtask

    initial begin
        clear_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 4'h0;
        tx_dir   = 1'b0;
        rx_req   = 1'b0;
        rx_dir   = 1'b0;
        ser_in   = 1'b0;
        rx_ready = 1'b0;
        $display("[TB] starting usr_seq_ctrl bench");
        test_reset();
        test_tx(4'b1011, 1'b0, 4'b1011);
        test_tx(4'b1011, 1'b1, 4'b1101);
        test_back_to_back();
        test_rx(1'b0, 4'b1110, 4'hE);
        test_rx(1'b1, 4'b1110, 4'h7);
        test_arbitration();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usr_seq_ctrl.md
USR_SEQ_CTRL -- requirements
Module: usr_seq_ctrl

Interface
REQ-001 SHALL have parameter FILL, default 1'b0: bit shifted into the vacated end during TX shifts.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port clear_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port tx_valid  in  1  TX word offered.
REQ-005 SHALL have port tx_ready  out  1  TX word accepted when tx_valid & tx_ready.
REQ-006 SHALL have port tx_data  in  4  parallel word to serialize.
REQ-007 SHALL have port tx_dir  in  1  0 = LSB-first (shift right), 1 = MSB-first (shift left); sampled at TX handshake.
REQ-008 SHALL have port ser_out / ser_out_valid  out  1 / 1  serial TX bit and its qualifier.
REQ-009 SHALL have port rx_req  in  1  level request for one 4-bit RX frame; held until rx_ack.
REQ-010 SHALL have port rx_dir  in  1  0 = LSB arrives first, 1 = MSB first; sampled at rx_ack.
REQ-011 SHALL have port rx_ack  out  1  one-cycle RX grant pulse.
REQ-012 SHALL have port ser_in  in  1  serial RX bit.
REQ-013 SHALL have port rx_valid / rx_ready  out / in  1 / 1  RX word handshake.
REQ-014 SHALL have port rx_data  out  4  assembled RX word.
REQ-015 SHALL have port busy  out  1  high in any state except IDLE.
REQ-016 SHALL have port usr_s  out  2  shift-register mode: 00 hold, 01 right, 10 left, 11 load.
REQ-017 SHALL have ports usr_i (out 4), usr_msb_in (out 1), usr_lsb_in (out 1), usr_a (in 4); these connect to the 4-bit shift register.

Function
REQ-018 SHALL implement FSM states IDLE, TX_SHIFT, RX_SHIFT, RX_DONE, plus a 2-bit bit_cnt, dir reg and last_grant reg.
REQ-019 IDLE: usr_s=00; tx_ready=1 when the arbiter selects TX; rx_ack=1 when it selects RX.
REQ-020 Arbiter in IDLE: a single requester wins; with tx_valid & rx_req both high, grant goes to the side not granted last (round-robin).
REQ-021 TX handshake cycle: usr_s=11, usr_i=tx_data; the word loads on that edge; next state TX_SHIFT, bit_cnt=0.
REQ-022 TX_SHIFT: ser_out_valid=1; ser_out=usr_a[0] (dir 0) or usr_a[3] (dir 1); usr_s=01 with usr_msb_in=FILL, or 10 with usr_lsb_in=FILL; bit_cnt increments.
REQ-023 TX latency: bit k of the word appears exactly k+1 cycles after the handshake; 4 valid bits, contiguous.
REQ-024 Last TX bit (bit_cnt=3): if tx_valid & !rx_req, tx_ready=1, usr_s=11 loads the next word, and the FSM stays in TX_SHIFT with bit_cnt=0 (gapless); otherwise next state IDLE.
REQ-025 rx_ack cycle: usr_s=00; next state RX_SHIFT, bit_cnt=0.
REQ-026 RX_SHIFT: for dir 0, usr_s=01 with usr_msb_in=ser_in; for dir 1, usr_s=10 with usr_lsb_in=ser_in; 4 cycles, then RX_DONE.
REQ-027 Bit order: the first received bit ends in rx_data[0] (dir 0) or rx_data[3] (dir 1).
REQ-028 RX_DONE: rx_valid=1, rx_data=usr_a held stable (usr_s=00) until rx_ready; then IDLE; rx_valid is never dropped without rx_ready.
REQ-029 rx_data SHALL equal usr_a in all states; it is valid only with rx_valid.
REQ-030 tx_valid and rx_req SHALL be ignored outside IDLE, except under REQ-024.
REQ-031 last_grant SHALL update on every TX handshake and every rx_ack.

Reset
REQ-032 While clear_n=0: usr_s=11 and usr_i=0, so the shift register clears on the same edge; tx_ready, rx_ack, ser_out_valid and rx_valid are 0.
REQ-033 After the reset edge: state=IDLE, bit_cnt=0, dir=0, last_grant=RX (TX wins the first tie), busy=0, ser_out=0.
REQ-034 Reset mid-TX or mid-RX SHALL abort the frame; no partial rx_valid is issued afterwards.

Structure
REQ-035 Shared package: state encoding, usr_s mode constants (HOLD/SHR/SHL/LOAD), and frame width 4.
REQ-036 Purely sequential control; no sub-module is needed. The integration top instantiates Universal_shift_reg beside usr_seq_ctrl, with its clear tied low.

Verification
REQ-037 Reset, then tx_data=4'b1011, dir=0 -> ser_out 1,1,0,1 on cycles 1-4 after the handshake; busy low on cycle 5.
REQ-038 Same word with dir=1 -> ser_out 1,0,1,1; two words back-to-back -> 8 contiguous valid bits, no gap.
REQ-039 rx_req, dir=0, ser_in 0,1,1,1 -> rx_data=4'hE; holding rx_ready=0 for 3 cycles -> rx_valid and data stable; rx_ready -> IDLE.
REQ-040 tx_valid & rx_req high together from reset -> TX first, then RX granted next, then TX (alternation); gapless reload suppressed while rx_req is high.
REQ-041 clear_n low during RX_SHIFT bit 2 -> IDLE, usr_a=0, no rx_valid; a new TX then completes correctly.
